uart_tx_arbiter: RTL and testbench

- Shares one tx_uart instance between NUM_REQ byte producers (CPU console, debug monitor, boot ROM printer, ...).
- Arbitrates round-robin per byte. An optional lock lets one requester keep the UART for a whole message so lines do not interleave.
- Drives tx_uart's valid/tx_data and consumes its one-cycle ready pulse. Sits between the SoC IO bus slaves and tx_uart.

---
 rtl/uart_tx_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, per-byte arbiter that shares one tx_uart between NUM_REQ byte producers.
// Optional macro UART_ARB_CRLF_EN expands a loaded 0x0A into the pair 0x0D, 0x0A.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned LOCK_TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_lock,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_valid,
    output logic [7:0]           uart_data,
    input  logic                 uart_ready,
    output logic [ID_W-1:0]      grant_id,
    output logic                 lock_active,
    output logic                 busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_BUSY,
`ifdef UART_ARB_CRLF_EN
        ST_LOAD_LF,
`endif
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    rr_q, rr_d;
    logic [15:0]        tmo_q, tmo_d;
    logic               valid_d, lock_d, busy_d;
    logic [7:0]         data_d;
    logic [NUM_REQ-1:0] ready_d;
    logic [ID_W-1:0]    grant_d;
`ifdef UART_ARB_CRLF_EN
    logic               crlf_q, crlf_d;
`endif

    logic               found, owner_valid, eligible;
    logic [ID_W-1:0]    pick, sel;
    logic [7:0]         sel_byte;
    logic               sel_lock;

    // First valid requester at or after rr_q, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        idx   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(rr_q) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!found && j == idx && req_valid[j]) begin
                    found = 1'b1;
                    pick  = ID_W'(j);
                end
            end
        end
    end

    // While locked only the owner may be chosen.
    always_comb begin
        owner_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == grant_id) owner_valid = req_valid[k];
        end
        sel      = lock_active ? grant_id : pick;
        eligible = lock_active ? owner_valid : found;
        sel_byte = '0;
        sel_lock = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (ID_W'(k) == sel) begin
                sel_byte = req_data[8*k +: 8];
                sel_lock = req_lock[k];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        tmo_d   = tmo_q;
        valid_d = uart_valid;
        data_d  = uart_data;
        ready_d = '0;
        grant_d = grant_id;
        lock_d  = lock_active;
`ifdef UART_ARB_CRLF_EN
        crlf_d  = crlf_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (eligible) begin
                    state_d = ST_LOAD;
                    data_d  = sel_byte;
                    valid_d = 1'b1;
                    for (int unsigned k = 0; k < NUM_REQ; k++) begin
                        ready_d[k] = (ID_W'(k) == sel);
                    end
                    grant_d = sel;
                    rr_d    = (sel == ID_W'(NUM_REQ - 1)) ? '0 : sel + ID_W'(1);
                    lock_d  = sel_lock;
                    tmo_d   = '0;
`ifdef UART_ARB_CRLF_EN
                    if (sel_byte == 8'h0A) begin
                        data_d = 8'h0D;
                        crlf_d = 1'b1;
                    end
`endif
                end else if (lock_active) begin
                    if (tmo_q == 16'(LOCK_TIMEOUT - 1)) begin
                        lock_d = 1'b0;
                        tmo_d  = '0;
                    end else begin
                        tmo_d = tmo_q + 16'd1;
                    end
                end
            end
            ST_LOAD: state_d = ST_BUSY;
            ST_BUSY: begin
                if (uart_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
`ifdef UART_ARB_CRLF_EN
                if (crlf_q) begin
                    state_d = ST_LOAD_LF;
                    data_d  = 8'h0A;
                    valid_d = 1'b1;
                    crlf_d  = 1'b0;
                end
`endif
            end
`ifdef UART_ARB_CRLF_EN
            ST_LOAD_LF: state_d = ST_BUSY;
`endif
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            rr_q        <= '0;
            tmo_q       <= '0;
            uart_valid  <= 1'b0;
            uart_data   <= '0;
            req_ready   <= '0;
            grant_id    <= '0;
            lock_active <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_ARB_CRLF_EN
            crlf_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            tmo_q       <= tmo_d;
            uart_valid  <= valid_d;
            uart_data   <= data_d;
            req_ready   <= ready_d;
            grant_id    <= grant_d;
            lock_active <= lock_d;
            busy        <= busy_d;
`ifdef UART_ARB_CRLF_EN
            crlf_q      <= crlf_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus lock, timeout and reset sequences.
// Includes a behavioural tx_uart (div=4, 10-bit frame) that logs every byte it accepts.
module tb_uart_tx_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;

    logic               clk = 1'b0;
    logic               resetn = 1'b0;
    logic [NUM_REQ-1:0] req_valid = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0] req_lock = '0;
    logic [NUM_REQ-1:0] req_ready;
    logic               uart_valid;
    logic [7:0]         uart_data;
    logic               uart_ready;
    logic [ID_W-1:0]    grant_id;
    logic               lock_active;
    logic               busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .LOCK_TIMEOUT(8)) dut (
        .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
        .req_lock(req_lock), .req_ready(req_ready), .uart_valid(uart_valid),
        .uart_data(uart_data), .uart_ready(uart_ready), .grant_id(grant_id),
        .lock_active(lock_active), .busy(busy)
    );

    // tx_uart model: 10 bits x 4 clocks per frame, ready pulses for the frame's final cycle.
    logic [7:0] tx_log[$];
    logic [5:0] mdl_cnt;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mdl_cnt    <= '0;
            uart_ready <= 1'b0;
        end else if (mdl_cnt == 0) begin
            uart_ready <= 1'b0;
            if (uart_valid) begin
                tx_log.push_back(uart_data);
                mdl_cnt <= 6'd41;
            end
        end else begin
            mdl_cnt    <= mdl_cnt - 6'd1;
            uart_ready <= (mdl_cnt == 6'd2);
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    int unsigned rdy_cnt[NUM_REQ];

    typedef struct {
        bit          rst;
        logic [3:0]  valid;
        logic [31:0] data;
        int unsigned nexp;
        logic [31:0] exp;
        logic [1:0]  last_id;
    } vec_t;
    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) rdy_cnt[i]++;
    endtask

    task automatic drop_served();
        for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) req_valid[i] = 1'b0;
    endtask

    task automatic clear_obs();
        tx_log.delete();
        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
    endtask

    task automatic run_until_idle(input string name);
        int unsigned n = 0;
        while (!(req_valid == '0 && !busy && mdl_cnt == 0) && n < 600) begin
            step();
            drop_served();
            n++;
        end
        check({name, " done"}, 32'(n < 600), 32'd1);
    endtask

    task automatic check_log(input string name, input int unsigned nexp, input logic [31:0] exp);
        logic [7:0] got;
        check({name, " count"}, 32'(tx_log.size()), 32'(nexp));
        for (int unsigned k = 0; k < nexp; k++) begin
            got = (k < 32'(tx_log.size())) ? tx_log[k] : 8'hxx;
            check($sformatf("%s byte%0d", name, k), {24'd0, got}, {24'd0, exp[8*k +: 8]});
        end
    endtask

    task automatic wait_ready(input string name, input int idx);
        int unsigned n = 0;
        while (!req_ready[idx] && n < 200) begin
            step();
            n++;
        end
        check({name, " ready seen"}, 32'(req_ready[idx]), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned cnt;
        bit early, lock_break;
        int phase, n;

        tbl[0] = '{1'b0, 4'b0001, 32'h0000_0041, 1, 32'h0000_0041, 2'd0};
        tbl[1] = '{1'b1, 4'b1111, 32'h1312_1110, 4, 32'h1312_1110, 2'd3};
        tbl[2] = '{1'b0, 4'b1010, 32'h2300_2100, 2, 32'h0000_2321, 2'd3};
        tbl[3] = '{1'b0, 4'b0101, 32'h0052_0050, 2, 32'h0000_5250, 2'd2};
        tbl[4] = '{1'b0, 4'b1001, 32'h6300_0060, 2, 32'h0000_6063, 2'd0};
        tbl[5] = '{1'b0, 4'b0011, 32'h0000_7170, 2, 32'h0000_7071, 2'd0};
        tbl[6] = '{1'b0, 4'b0100, 32'h00FF_0000, 1, 32'h0000_00FF, 2'd2};
        tbl[7] = '{1'b0, 4'b1000, 32'h0000_0000, 1, 32'h0000_0000, 2'd3};
`ifdef UART_ARB_CRLF_EN
        tbl[8] = '{1'b0, 4'b0011, 32'h0000_310A, 3, 32'h0031_0A0D, 2'd1};
`else
        tbl[8] = '{1'b0, 4'b0011, 32'h0000_310A, 2, 32'h0000_310A, 2'd1};
`endif
        tbl[9] = '{1'b0, 4'b1110, 32'h8382_8100, 3, 32'h0081_8382, 2'd1};

        clear_obs();
        step();
        step();
        check("rst uart_valid", 32'(uart_valid), 32'd0);
        check("rst uart_data", 32'(uart_data), 32'd0);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst grant_id", 32'(grant_id), 32'd0);
        check("rst lock_active", 32'(lock_active), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        step();

        for (int t = 0; t < 10; t++) begin
            if (tbl[t].rst) begin
                resetn = 1'b0;
                step();
                step();
                resetn = 1'b1;
                step();
            end
            clear_obs();
            req_lock  = '0;
            req_data  = tbl[t].data;
            req_valid = tbl[t].valid;
            run_until_idle($sformatf("T%0d", t));
            check_log($sformatf("T%0d", t), tbl[t].nexp, tbl[t].exp);
            for (int i = 0; i < NUM_REQ; i++)
                check($sformatf("T%0d rdy%0d", t, i), rdy_cnt[i], 32'(tbl[t].valid[i]));
            check($sformatf("T%0d grant_id", t), 32'(grant_id), 32'(tbl[t].last_id));
            check($sformatf("T%0d lock", t), 32'(lock_active), 32'd0);
        end

        // Lock: req 2 holds the UART across "AB" although req 0 is next in round-robin order.
        clear_obs();
        req_data[23:16] = 8'h41; req_lock[2] = 1'b1; req_valid[2] = 1'b1;
        req_data[7:0]   = 8'h30; req_lock[0] = 1'b0; req_valid[0] = 1'b1;
        phase = 0; lock_break = 1'b0; n = 0;
        while (!(req_valid == '0 && !busy && mdl_cnt == 0) && n < 600) begin
            step();
            if (req_ready[2]) begin
                if (phase == 0) begin
                    check("lock A grant", 32'(grant_id), 32'd2);
                    check("lock A lock", 32'(lock_active), 32'd1);
                    req_data[23:16] = 8'h42; req_lock[2] = 1'b0;
                    phase = 1;
                end else begin
                    check("lock B unlock", 32'(lock_active), 32'd0);
                    req_valid[2] = 1'b0;
                    phase = 2;
                end
            end else if (phase == 1 && !lock_active) begin
                lock_break = 1'b1;
            end
            if (req_ready[0]) req_valid[0] = 1'b0;
            n++;
        end
        check("lock done", 32'(n < 600), 32'd1);
        check("lock held A..B", 32'(lock_break), 32'd0);
        check_log("lock", 3, 32'h0030_4241);
        check("lock rdy2", rdy_cnt[2], 32'd2);
        check("lock rdy0", rdy_cnt[0], 32'd1);

        // Timeout: req 1 locks then goes silent; lock drops 8 cycles into IDLE, then req 3.
        clear_obs();
        req_data[15:8]  = 8'h55; req_lock[1] = 1'b1; req_valid[1] = 1'b1;
        req_data[31:24] = 8'h77; req_lock[3] = 1'b0; req_valid[3] = 1'b1;
        wait_ready("tmo req1", 1);
        req_valid[1] = 1'b0; req_lock[1] = 1'b0;
        check("tmo grant1", 32'(grant_id), 32'd1);
        check("tmo locked", 32'(lock_active), 32'd1);
        n = 0;
        while (busy && n < 200) begin step(); n++; end
        cnt = 0; early = 1'b0;
        while (lock_active && cnt < 50) begin
            step();
            cnt++;
            if (req_ready[3]) early = 1'b1;
        end
        check("tmo cycles", cnt, 32'd8);
        check("tmo no early grant", 32'(early), 32'd0);
        step();
        check("tmo req3 ready", 32'(req_ready[3]), 32'd1);
        check("tmo grant3", 32'(grant_id), 32'd3);
        drop_served();
        run_until_idle("tmo");
        check_log("tmo", 2, 32'h0000_7755);

        // Reset during BUSY: everything clears at once, arbitration restarts from index 0.
        clear_obs();
        req_data[23:16] = 8'h99; req_lock[2] = 1'b1; req_valid[2] = 1'b1;
        wait_ready("rst req2", 2);
        req_valid[2] = 1'b0; req_lock[2] = 1'b0;
        req_data[15:8] = 8'hA1; req_data[31:24] = 8'hA3;
        req_valid[1] = 1'b1; req_valid[3] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("pre-rst busy", 32'(busy), 32'd1);
        check("pre-rst valid", 32'(uart_valid), 32'd1);
        #3;
        resetn = 1'b0;
        #1;
        check("mid-rst uart_valid", 32'(uart_valid), 32'd0);
        check("mid-rst busy", 32'(busy), 32'd0);
        check("mid-rst lock", 32'(lock_active), 32'd0);
        check("mid-rst grant_id", 32'(grant_id), 32'd0);
        @(posedge clk);
        #1;
        clear_obs();
        resetn = 1'b1;
        run_until_idle("post-rst");
        check_log("post-rst", 2, 32'h0000_A3A1);
        check("post-rst grant", 32'(grant_id), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
